// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: hit service, dirty-victim writeback, line refill.
// Optional hit/miss performance counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int s_index = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic [1:0] hit,
  input  logic [1:0] dirty,
  input  logic       lru,
  input  logic       pmem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic [1:0] ld_tag,
  output logic [1:0] ld_valid,
  output logic [1:0] ld_dirty,
  output logic [1:0] ld_data,
  output logic       dirty_in,
  output logic       ld_lru,
  output logic       lru_in,
  output logic       data_sel,
  output logic       addr_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  if (s_index < 1) begin : g_s_index_check
    $error("cache_control: s_index must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } state_t;

  state_t state;

  logic req;
  logic hit_any;
  logic hit_way;
  logic miss_go;

  assign req     = mem_read | mem_write;
  assign hit_any = |hit;
  // Way 0 wins when both ways report a match.
  assign hit_way = ~hit[0];
  assign miss_go = (state == COMPARE) && req && !hit_any;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (req) state <= COMPARE;
        COMPARE: begin
          if (!req || hit_any) state <= IDLE;
          else if (dirty[lru]) state <= WRITEBACK;
          else state <= FETCH;
        end
        WRITEBACK: if (pmem_resp) state <= FETCH;
        FETCH:     if (pmem_resp) state <= COMPARE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    ld_tag     = 2'b00;
    ld_valid   = 2'b00;
    ld_dirty   = 2'b00;
    ld_data    = 2'b00;
    dirty_in   = 1'b0;
    ld_lru     = 1'b0;
    lru_in     = 1'b0;
    data_sel   = 1'b0;
    addr_sel   = 1'b0;
    case (state)
      COMPARE: begin
        if (req && hit_any) begin
          mem_resp = 1'b1;
          ld_lru   = 1'b1;
          lru_in   = ~hit_way;
          if (mem_write) begin
            ld_data[hit_way]  = 1'b1;
            ld_dirty[hit_way] = 1'b1;
            dirty_in          = 1'b1;
            data_sel          = 1'b0;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
      end
      FETCH: begin
        pmem_read = 1'b1;
        addr_sel  = 1'b0;
        if (pmem_resp) begin
          ld_data[lru]  = 1'b1;
          ld_tag[lru]   = 1'b1;
          ld_valid[lru] = 1'b1;
          ld_dirty[lru] = 1'b1;
          dirty_in      = 1'b0;
          data_sel      = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // refill marks a COMPARE re-entered after a line fill, so its hit is not counted again.
  logic refill;

  always_ff @(posedge clk) begin
    if (!rst) begin
      refill     <= 1'b0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (miss_go) begin
        refill <= 1'b1;
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end else if (state == COMPARE) begin
        refill <= 1'b0;
      end
      if ((state == COMPARE) && req && hit_any && !refill && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed vector table plus randomized run against a behavioural model.
module tb_cache_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_read, mem_write, lru, pmem_resp;
  logic [1:0] hit, dirty;
  logic       mem_resp, pmem_read, pmem_write, dirty_in, ld_lru, lru_in, data_sel, addr_sel;
  logic [1:0] ld_tag, ld_valid, ld_dirty, ld_data;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_control #(.s_index(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .lru(lru), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .ld_tag(ld_tag), .ld_valid(ld_valid), .ld_dirty(ld_dirty), .ld_data(ld_data),
    .dirty_in(dirty_in), .ld_lru(ld_lru), .lru_in(lru_in), .data_sel(data_sel), .addr_sel(addr_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Output bundle: {mem_resp, pmem_read, pmem_write, ld_tag, ld_valid, ld_dirty, ld_data,
  //                 dirty_in, ld_lru, lru_in, data_sel, addr_sel}
  wire [15:0] outs = {mem_resp, pmem_read, pmem_write, ld_tag, ld_valid, ld_dirty, ld_data,
                      dirty_in, ld_lru, lru_in, data_sel, addr_sel};

  typedef struct {
    logic       rst, rd, wr;
    logic [1:0] hit, dirty;
    logic       lru, pr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[20];
  int applied = 0;
  int miscompares = 0;

  task automatic drive(input logic r, input logic rd, input logic wr, input logic [1:0] h,
                       input logic [1:0] d, input logic l, input logic p);
    rst = r; mem_read = rd; mem_write = wr; hit = h; dirty = d; lru = l; pmem_resp = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: where the request is in its life, plus whether it has been refilled.
  typedef enum int {M_IDLE, M_LOOKUP, M_EVICT, M_FILL} mphase_e;
  mphase_e m_phase;
  bit      m_refilled;
  longint  m_hits, m_misses;

  function automatic logic [15:0] model_out(input logic rd, input logic wr, input logic [1:0] h,
                                            input logic l, input logic p);
    logic [15:0] o;
    int way;
    o = '0;
    if (m_phase == M_LOOKUP && (rd || wr) && h != 2'b00) begin
      way = h[0] ? 0 : 1;
      o[15] = 1'b1;
      o[3]  = 1'b1;
      o[2]  = (way == 0);
      if (wr) begin
        o[8:7] = 2'(1 << way);
        o[6:5] = 2'(1 << way);
        o[4]   = 1'b1;
      end
    end else if (m_phase == M_EVICT) begin
      o[13] = 1'b1;
      o[0]  = 1'b1;
    end else if (m_phase == M_FILL) begin
      o[14] = 1'b1;
      if (p) begin
        o[12:11] = 2'(1 << l);
        o[10:9]  = 2'(1 << l);
        o[8:7]   = 2'(1 << l);
        o[6:5]   = 2'(1 << l);
        o[1]     = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic model_step(input logic r, input logic rd, input logic wr, input logic [1:0] h,
                            input logic [1:0] d, input logic l, input logic p);
    if (!r) begin
      m_phase = M_IDLE; m_refilled = 0; m_hits = 0; m_misses = 0;
      return;
    end
    case (m_phase)
      M_IDLE:  if (rd || wr) m_phase = M_LOOKUP;
      M_LOOKUP: begin
        if (!(rd || wr)) begin
          m_phase = M_IDLE; m_refilled = 0;
        end else if (h != 2'b00) begin
          if (!m_refilled && m_hits < 64'hFFFF_FFFF) m_hits++;
          m_phase = M_IDLE; m_refilled = 0;
        end else begin
          if (m_misses < 64'hFFFF_FFFF) m_misses++;
          m_refilled = 1;
          m_phase = d[l] ? M_EVICT : M_FILL;
        end
      end
      M_EVICT: if (p) m_phase = M_FILL;
      M_FILL:  if (p) m_phase = M_LOOKUP;
      default: m_phase = M_IDLE;
    endcase
  endtask

  initial begin
    //          rst rd wr hit    dirty  lru pr  expected
    tbl[0]  = '{0, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000}; // reset held with request
    tbl[1]  = '{0, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000};
    tbl[2]  = '{1, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000}; // IDLE sees request
    tbl[3]  = '{1, 1, 0, 2'b10, 2'b00, 0, 0, 16'h8008}; // read hit way 1
    tbl[4]  = '{1, 0, 1, 2'b01, 2'b00, 0, 0, 16'h0000};
    tbl[5]  = '{1, 0, 1, 2'b01, 2'b00, 0, 0, 16'h80BC}; // write hit way 0
    tbl[6]  = '{1, 1, 0, 2'b00, 2'b10, 1, 0, 16'h0000};
    tbl[7]  = '{1, 1, 0, 2'b00, 2'b10, 1, 0, 16'h0000}; // dirty miss
    tbl[8]  = '{1, 1, 0, 2'b00, 2'b10, 1, 0, 16'h2001}; // writeback
    tbl[9]  = '{1, 1, 0, 2'b00, 2'b10, 1, 1, 16'h2001};
    tbl[10] = '{1, 1, 0, 2'b00, 2'b10, 1, 0, 16'h4000}; // fetch
    tbl[11] = '{1, 1, 0, 2'b00, 2'b10, 1, 1, 16'h5542}; // refill strobes way 1
    tbl[12] = '{1, 1, 0, 2'b10, 2'b00, 1, 0, 16'h8008}; // refilled line hits
    tbl[13] = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 16'h0000};
    tbl[14] = '{1, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000};
    tbl[15] = '{1, 1, 0, 2'b00, 2'b00, 0, 0, 16'h0000}; // clean miss
    tbl[16] = '{1, 1, 0, 2'b00, 2'b00, 0, 0, 16'h4000};
    tbl[17] = '{0, 1, 0, 2'b00, 2'b00, 0, 0, 16'h4000}; // reset edge mid-fetch
    tbl[18] = '{1, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0000}; // late pmem_resp ignored
    tbl[19] = '{1, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0000};

    drive(0, 1, 0, 2'b00, 2'b00, 0, 0);
    @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].hit, tbl[i].dirty, tbl[i].lru, tbl[i].pr);
      #1;
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
`ifdef CACHE_PERF_CNT_EN
      if (i == 14) begin
        check("hit_count_after_dirty_miss", hit_count, 32'd2);
        check("miss_count_after_dirty_miss", miss_count, 32'd1);
      end
      if (i == 18) begin
        check("hit_count_after_reset", hit_count, 32'd0);
        check("miss_count_after_reset", miss_count, 32'd0);
      end
`endif
    end

`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    force dut.hit_count = 32'hFFFF_FFFE;
    #1 release dut.hit_count;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1, 1, 0, 2'b01, 2'b00, 0, 0);
      @(negedge clk);
      drive(1, 1, 0, 2'b01, 2'b00, 0, 0);
      @(negedge clk);
      drive(1, 0, 0, 2'b00, 2'b00, 0, 0);
      #1 check($sformatf("hit_count_sat%0d", k), hit_count, 32'hFFFF_FFFF);
    end
`endif

    m_phase = M_IDLE; m_refilled = 0; m_hits = 0; m_misses = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, rd, wr, l, p;
      logic [1:0] h, d;
      logic [15:0] e;
      @(negedge clk);
      r  = (n == 0) ? 1'b0 : ($urandom_range(0, 40) != 0);
      rd = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      d  = 2'($urandom_range(0, 3));
      l  = 1'($urandom_range(0, 1));
      p  = ($urandom_range(0, 2) == 0);
      drive(r, rd, wr, h, d, l, p);
      #1;
      e = model_out(rd, wr, h, l, p);
      if (n > 0) begin
        check($sformatf("rand%0d", n), 32'(outs), 32'(e));
        if (pmem_read && pmem_write) check("pmem_exclusive", 32'd1, 32'd0);
`ifdef CACHE_PERF_CNT_EN
        check($sformatf("rand%0d_hits", n), hit_count, 32'(m_hits));
        check($sformatf("rand%0d_misses", n), miss_count, 32'(m_misses));
`endif
      end
      model_step(r, rd, wr, h, d, l, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
